// File: rtl/led_sequence_scheduler.sv
// Keypad LED scheduler: arbitrates key echo, "correct" and "wrong" animations
// and drives the packed 12-slot LED value bus (slot k at bits [4k-1:4k-4]).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | all slots dark, waiting for a request or a valid key
//   ECHO    | last valid key shown in its own slot until the first tick
//   CORRECT | alternating odd/even pattern on slots 1..6, CORRECT_TICKS long
//   WRONG   | all-on / all-off flash, WRONG_TICKS long, preemptable by correct
module led_sequence_scheduler #(
    parameter int TICK_DIV      = 25000000,
    parameter int CORRECT_TICKS = 6,
    parameter int WRONG_TICKS   = 4
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        req_correct,
    input  logic        req_wrong,
    output logic [47:0] led_values,
    output logic [1:0]  mode,
    output logic        busy,
    output logic        anim_done
);

    localparam int TDW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT   = (CORRECT_TICKS > WRONG_TICKS) ? CORRECT_TICKS : WRONG_TICKS;
    localparam int CNT_W  = $clog2(MAXT + 1);

    localparam logic [TDW-1:0]   TICK_LAST    = TDW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CORRECT_LAST = CNT_W'(CORRECT_TICKS - 1);
    localparam logic [CNT_W-1:0] WRONG_LAST   = CNT_W'(WRONG_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ECHO    = 2'b01,
        CORRECT = 2'b10,
        WRONG   = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [TDW-1:0]   tick_cnt, tick_cnt_nxt;
    logic [CNT_W-1:0] tick_num, tick_num_nxt;
    logic             phase, phase_nxt;
    logic [3:0]       key, key_nxt;
    logic             done_nxt;
    logic             restart;
    logic             tick;
    logic             key_ok;
    logic [47:0]      led_nxt;

    assign tick   = (tick_cnt == TICK_LAST);
    assign key_ok = key_valid && (key_code >= 4'd1) && (key_code <= 4'd12);
    assign mode   = state;

    // LED image for a given state/phase/key; computed from next-state values
    // so the registered bus lines up with the registered mode.
    function automatic logic [47:0] leds_for(input state_t st, input logic ph,
                                             input logic [3:0] k_code);
        logic [47:0] v;
        v = '0;
        for (int k = 0; k < 12; k++) begin
            case (st)
                ECHO:    if (k_code == 4'(k + 1)) v[4*k +: 4] = k_code;
                CORRECT: if (k < 6) v[4*k +: 4] = ph ? 4'(2*k + 2) : 4'(2*k + 1);
                WRONG:   if (!ph) v[4*k +: 4] = 4'hF;
                default: ;
            endcase
        end
        return v;
    endfunction

    // Next-state, tick/phase bookkeeping and completion pulse.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick ? '0 : tick_cnt + TDW'(1);
        tick_num_nxt = tick_num;
        phase_nxt    = phase;
        key_nxt      = key;
        done_nxt     = 1'b0;
        restart      = 1'b0;

        case (state)
            IDLE: begin
                if (req_correct)    state_nxt = CORRECT;
                else if (req_wrong) state_nxt = WRONG;
                else if (key_ok) begin
                    state_nxt = ECHO;
                    key_nxt   = key_code;
                end
            end
            ECHO: begin
                if (req_correct)    state_nxt = CORRECT;
                else if (req_wrong) state_nxt = WRONG;
                else if (key_ok) begin
                    // a fresh key replaces the shown one and restarts its timer
                    key_nxt = key_code;
                    restart = 1'b1;
                end
                else if (tick)      state_nxt = IDLE;
            end
            CORRECT: begin
                if (tick) begin
                    if (tick_num == CORRECT_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        phase_nxt    = ~phase;
                        tick_num_nxt = tick_num + CNT_W'(1);
                    end
                end
            end
            WRONG: begin
                if (req_correct) state_nxt = CORRECT;
                else if (tick) begin
                    if (tick_num == WRONG_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        phase_nxt    = ~phase;
                        tick_num_nxt = tick_num + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // every state entry (and echo re-entry) starts a clean timeline
        if (restart || (state_nxt != state)) begin
            tick_cnt_nxt = '0;
            tick_num_nxt = '0;
            phase_nxt    = 1'b0;
        end

        led_nxt = leds_for(state_nxt, phase_nxt, key_nxt);
    end

    // State, timers and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            tick_num   <= '0;
            phase      <= 1'b0;
            key        <= '0;
            led_values <= '0;
            busy       <= 1'b0;
            anim_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            tick_num   <= tick_num_nxt;
            phase      <= phase_nxt;
            key        <= key_nxt;
            led_values <= led_nxt;
            busy       <= (state_nxt != IDLE);
            anim_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_led_sequence_scheduler.sv
// Bench for led_sequence_scheduler: directed scenarios followed by random
// traffic, all checked against a timeline-based reference model.
module tb_led_sequence_scheduler;

    localparam int TD = 4;
    localparam int CT = 6;
    localparam int WT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = '0;
    logic        req_correct = 1'b0;
    logic        req_wrong = 1'b0;
    logic [47:0] led_values;
    logic [1:0]  mode;
    logic        busy;
    logic        anim_done;

    int n_vec = 0;
    int n_err = 0;

    led_sequence_scheduler #(
        .TICK_DIV(TD), .CORRECT_TICKS(CT), .WRONG_TICKS(WT)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
        .req_correct(req_correct), .req_wrong(req_wrong), .led_values(led_values),
        .mode(mode), .busy(busy), .anim_done(anim_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 echo, 2 correct, 3 wrong. Everything
    // timing-related is derived from how many edges have passed since entry.
    int edge_no = 0;
    int entry_edge = 0;
    int m_mode = 0;
    int m_key = 0;
    bit m_done = 0;
    int m_el, m_ticks, m_next;
    bit m_tick, m_restart, m_kok;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode = 0;
            m_done = 0;
            entry_edge = edge_no;
        end else begin
            edge_no++;
            m_el      = edge_no - entry_edge;
            m_tick    = (m_el > 0) && (m_el % TD == 0);
            m_ticks   = m_el / TD;
            m_kok     = key_valid && key_code >= 1 && key_code <= 12;
            m_next    = m_mode;
            m_restart = 0;
            m_done    = 0;
            case (m_mode)
                0: begin
                    if (req_correct) m_next = 2;
                    else if (req_wrong) m_next = 3;
                    else if (m_kok) begin m_next = 1; m_key = int'(key_code); end
                end
                1: begin
                    if (req_correct) m_next = 2;
                    else if (req_wrong) m_next = 3;
                    else if (m_kok) begin m_key = int'(key_code); m_restart = 1; end
                    else if (m_tick) m_next = 0;
                end
                2: if (m_tick && m_ticks == CT) begin m_next = 0; m_done = 1; end
                default: begin
                    if (req_correct) m_next = 2;
                    else if (m_tick && m_ticks == WT) begin m_next = 0; m_done = 1; end
                end
            endcase
            if (m_restart || m_next != m_mode) entry_edge = edge_no;
            m_mode = m_next;
        end
    end

    function automatic logic [47:0] exp_leds(input int md, input int ph, input int k);
        logic [47:0] v;
        v = '0;
        for (int s = 1; s <= 12; s++) begin
            if (md == 1 && s == k) v[4*s-1 -: 4] = 4'(k);
            if (md == 2 && s <= 6) v[4*s-1 -: 4] = 4'(ph == 0 ? 2*s - 1 : 2*s);
            if (md == 3 && ph == 0) v[4*s-1 -: 4] = 4'hF;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            chk("led_values", 64'(led_values),
                64'(exp_leds(m_mode, ((edge_no - entry_edge) / TD) % 2, m_key)));
            chk("mode", 64'(mode), 64'(m_mode));
            chk("busy", 64'(busy), 64'(m_mode != 0));
            chk("anim_done", 64'(anim_done), 64'(m_done));
        end
    end

    task automatic step(input bit kv, input logic [3:0] kc, input bit rc, input bit rw);
        @(negedge clk);
        key_valid   = kv;
        key_code    = kc;
        req_correct = rc;
        req_wrong   = rw;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0);
    endtask

    // async reset between edges; outputs must clear without a clock
    task automatic pulse_reset();
        @(posedge clk);
        #2 resetn = 1'b0;
        key_valid = 0; req_correct = 0; req_wrong = 0;
        #1;
        chk("rst_led", 64'(led_values), 64'd0);
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_done", 64'(anim_done), 64'd0);
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
    endtask

    int hold_rc, hold_rw;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_led", 64'(led_values), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1 resetn = 1'b1;

        // key echo and its expiry
        step(1, 4'd5, 0, 0);
        idle(6);
        // out-of-range keys ignored
        step(1, 4'd0, 0, 0);
        step(1, 4'd13, 0, 0);
        idle(2);
        // echo replacement and preemption
        step(1, 4'd12, 0, 0);
        idle(2);
        step(1, 4'd1, 0, 0);
        idle(2);
        step(0, 4'd0, 0, 1);
        idle(3);
        step(1, 4'd7, 0, 0);
        step(0, 4'd0, 1, 0);
        idle(28);
        // full correct animation
        step(0, 4'd0, 1, 0);
        idle(28);
        // wrong, preempted by correct
        step(0, 4'd0, 0, 1);
        idle(5);
        step(0, 4'd0, 1, 0);
        idle(28);
        // full wrong animation
        step(0, 4'd0, 0, 1);
        idle(20);
        // key and correct together, then keys during correct
        step(1, 4'd3, 1, 0);
        step(1, 4'd9, 0, 1);
        step(1, 4'd2, 0, 0);
        idle(25);
        // held request retriggers after completion
        for (int i = 0; i < 60; i++) step(0, 4'd0, 1, 0);
        idle(28);
        // reset during pattern B
        step(0, 4'd0, 1, 0);
        idle(6);
        pulse_reset();
        idle(6);

        // random traffic
        hold_rc = 0;
        hold_rw = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_rc == 0 && $urandom_range(0, 60) == 0) hold_rc = $urandom_range(1, 10);
            if (hold_rw == 0 && $urandom_range(0, 40) == 0) hold_rw = $urandom_range(1, 10);
            step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), hold_rc > 0, hold_rw > 0);
            if (hold_rc > 0) hold_rc--;
            if (hold_rw > 0) hold_rw--;
            if ($urandom_range(0, 400) == 0) pulse_reset();
        end
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
